mkio_rt_sa: RTL and testbench



---
 rtl/mkio_pkg.sv | 30 +++
 rtl/mkio_rt_sa_if.sv | 24 ++
 rtl/mkio_rt_buf.sv | 41 ++++
 rtl/mkio_rt_sa.sv | 271 +++++++++++++++++++++++++++
 tb/tb_mkio_rt_sa.sv | 326 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mkio_pkg.sv
// Shared definitions for the MKIO remote-terminal message engine:
// FSM encodings, command word layout and the status word builder.
package mkio_pkg;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_DECODE   = 3'd1;
  localparam logic [2:0] ST_RX_WAIT  = 3'd2;
  localparam logic [2:0] ST_RX_STORE = 3'd3;
  localparam logic [2:0] ST_STATUS   = 3'd4;
  localparam logic [2:0] ST_TX_DATA  = 3'd5;

  localparam logic [4:0] SA_MODE0   = 5'd0;
  localparam logic [4:0] SA_MODE31  = 5'd31;
  localparam logic [4:0] BCAST_ADDR = 5'd31;

  // Command word: [15:11] addr, [10] T/R (1 = RT transmits), [9:5] SA, [4:0] WC.
  typedef struct packed {
    logic [4:0] addr;
    logic       tr;
    logic [4:0] sa;
    logic [4:0] wc;
  } cmd_t;

  function automatic logic [15:0] status_word(input logic [4:0] addr,
                                              input logic me,
                                              input logic bcr);
    status_word = {addr, me, 5'd0, bcr, 4'd0};
  endfunction

endpackage

// File: rtl/mkio_rt_sa_if.sv
// Word-level link between the Manchester decoder/encoder pair (master)
// and the remote-terminal engine (slave).
interface mkio_rt_sa_if;
  // rx_done/tx_ready/tx_done are single-cycle strobes; rx_* and tx_* data
  // fields are only meaningful in the cycle their strobe is high.
  logic        rx_done;
  logic        rx_cd;
  logic [15:0] rx_data;
  logic        p_error;
  logic [15:0] tx_data;
  logic        tx_cd;
  logic        tx_ready;
  logic        tx_done;

  modport master (
    output rx_done, rx_cd, rx_data, p_error, tx_done,
    input  tx_data, tx_cd, tx_ready
  );

  modport slave (
    input  rx_done, rx_cd, rx_data, p_error, tx_done,
    output tx_data, tx_cd, tx_ready
  );
endinterface

// File: rtl/mkio_rt_buf.sv
// Subaddress data buffer: RT port and host port, registered reads.
// An RT write in a cycle suppresses any host write in that cycle.
module mkio_rt_buf #(
  parameter int DEPTH = 128,
  parameter int AW    = 7
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          rt_we_i,
  input  logic [AW-1:0] rt_waddr_i,
  input  logic [15:0]   rt_wdata_i,
  input  logic [AW-1:0] rt_raddr_i,
  output logic [15:0]   rt_rdata_o,
  input  logic          host_we_i,
  input  logic [AW-1:0] host_addr_i,
  input  logic [15:0]   host_wdata_i,
  output logic [15:0]   host_rdata_o
);

  logic [15:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (rt_we_i) begin
      mem_q[rt_waddr_i] <= rt_wdata_i;
    end else if (host_we_i) begin
      mem_q[host_addr_i] <= host_wdata_i;
    end
  end

  // Reads sample the array before this edge's write: same-cycle reads see old data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rt_rdata_o   <= '0;
      host_rdata_o <= '0;
    end else begin
      rt_rdata_o   <= mem_q[rt_raddr_i];
      host_rdata_o <= mem_q[host_addr_i];
    end
  end

endmodule

// File: rtl/mkio_rt_sa.sv
// MKIO / MIL-STD-1553 remote-terminal message engine with several data
// subaddresses, receive and transmit transfers, broadcast and timeout.
module mkio_rt_sa
  import mkio_pkg::*;
#(
  parameter logic [4:0]  ADDRESS      = 5'd1,
  parameter int          NUM_SA       = 4,
  parameter bit          BROADCAST_EN = 1'b1,
  parameter logic [15:0] TIMEOUT      = 16'd200,
  parameter int          SA_W         = $clog2(NUM_SA)
) (
  input  logic              clk,
  input  logic              reset,
  mkio_rt_sa_if.slave       bus,
  input  logic [SA_W+4:0]   host_addr_i,
  input  logic              host_we_i,
  input  logic [15:0]       host_wdata_i,
  output logic [15:0]       host_rdata_o,
  output logic              busy_o,
  output logic              msg_done_o,
  output logic [4:0]        msg_sa_o,
  output logic              msg_err_o,
  output logic [2:0]        state_o
);

  localparam logic [4:0] NUM_SA_L = 5'(NUM_SA);

  logic [2:0]  state_q, state_d;
  logic [4:0]  sa_q, sa_d, wc_q, wc_d, cnt_q, cnt_d;
  logic        tr_q, tr_d, bcast_q, bcast_d, tx_after_q, tx_after_d;
  logic [15:0] timer_q, timer_d;
  logic        sent_q, sent_d, me_q, me_d, bcr_q, bcr_d, sts_me_q, sts_me_d;
  logic [15:0] rx_word_q, rx_word_d;
  logic        perr_q, perr_d;
  logic [15:0] tx_data_q, tx_data_d;
  logic        tx_cd_q, tx_cd_d, tx_ready_q, tx_ready_d;
  logic        busy_q, busy_d, msg_done_q, msg_done_d, msg_err_q, msg_err_d;
  logic [4:0]  msg_sa_q, msg_sa_d;

  cmd_t            rx_cmd;
  logic            cmd_acc;
  logic            rt_we;
  logic [SA_W-1:0] bank;
  logic [15:0]     rt_rdata;
  logic            last_word;

  assign rx_cmd    = cmd_t'(bus.rx_data);
  assign cmd_acc   = bus.rx_done && bus.rx_cd &&
                     (rx_cmd.addr == ADDRESS ||
                      (BROADCAST_EN && rx_cmd.addr == BCAST_ADDR));
  assign bank      = sa_q[SA_W-1:0] - SA_W'(1);
  // WC = 0 gives wc_q - 1 = 31, i.e. 32 words with a wrapping counter.
  assign last_word = (cnt_q == wc_q - 5'd1);

  mkio_rt_buf #(.DEPTH(NUM_SA * 32), .AW(SA_W + 5)) u_buf (
    .clk          (clk),
    .reset        (reset),
    .rt_we_i      (rt_we),
    .rt_waddr_i   ({bank, cnt_q}),
    .rt_wdata_i   (rx_word_q),
    .rt_raddr_i   ({bank, cnt_d}),
    .rt_rdata_o   (rt_rdata),
    .host_we_i    (host_we_i),
    .host_addr_i  (host_addr_i),
    .host_wdata_i (host_wdata_i),
    .host_rdata_o (host_rdata_o)
  );

  always_comb begin
    state_d    = state_q;
    sa_d       = sa_q;
    wc_d       = wc_q;
    tr_d       = tr_q;
    bcast_d    = bcast_q;
    tx_after_d = tx_after_q;
    cnt_d      = cnt_q;
    timer_d    = timer_q;
    sent_d     = sent_q;
    me_d       = me_q;
    bcr_d      = bcr_q;
    sts_me_d   = sts_me_q;
    rx_word_d  = rx_word_q;
    perr_d     = perr_q;
    tx_data_d  = tx_data_q;
    tx_cd_d    = tx_cd_q;
    tx_ready_d = 1'b0;
    busy_d     = busy_q;
    msg_done_d = 1'b0;
    msg_sa_d   = msg_sa_q;
    msg_err_d  = msg_err_q;
    rt_we      = 1'b0;

    // An accepted command wins in every state, superseding any message in flight.
    if (cmd_acc) begin
      state_d = ST_DECODE;
      sa_d    = rx_cmd.sa;
      wc_d    = rx_cmd.wc;
      tr_d    = rx_cmd.tr;
      bcast_d = (rx_cmd.addr == BCAST_ADDR);
      sent_d  = 1'b0;
      busy_d  = 1'b1;
    end else begin
      case (state_q)
        ST_DECODE: begin
          if (sa_q == SA_MODE0 || sa_q == SA_MODE31) begin
            state_d    = ST_STATUS;
            tx_after_d = 1'b0;
          end else if (sa_q > NUM_SA_L || (bcast_q && tr_q)) begin
            me_d = 1'b1;
            if (bcast_q) begin
              state_d = ST_IDLE;
              busy_d  = 1'b0;
            end else begin
              state_d    = ST_STATUS;
              tx_after_d = 1'b0;
            end
          end else if (!tr_q) begin
            state_d = ST_RX_WAIT;
            cnt_d   = 5'd0;
            timer_d = 16'd0;
          end else begin
            state_d    = ST_STATUS;
            tx_after_d = 1'b1;
          end
        end

        ST_RX_WAIT: begin
          timer_d = timer_q + 16'd1;
          if (bus.rx_done && !bus.rx_cd) begin
            rx_word_d = bus.rx_data;
            perr_d    = bus.p_error;
            state_d   = ST_RX_STORE;
          end else if (timer_q == TIMEOUT) begin
            me_d      = 1'b1;
            msg_err_d = 1'b1;
            busy_d    = 1'b0;
            state_d   = ST_IDLE;
          end
        end

        ST_RX_STORE: begin
          rt_we = 1'b1;
          if (perr_q) me_d = 1'b1;
          if (last_word) begin
            if (bcast_q) begin
              bcr_d      = 1'b1;
              msg_done_d = 1'b1;
              msg_sa_d   = sa_q;
              msg_err_d  = me_q | perr_q;
              busy_d     = 1'b0;
              state_d    = ST_IDLE;
            end else begin
              state_d    = ST_STATUS;
              tx_after_d = 1'b0;
              sent_d     = 1'b0;
            end
          end else begin
            cnt_d   = cnt_q + 5'd1;
            timer_d = 16'd0;
            state_d = ST_RX_WAIT;
          end
        end

        ST_STATUS: begin
          if (!sent_q) begin
            tx_data_d  = status_word(ADDRESS, me_q, bcr_q);
            tx_cd_d    = 1'b0;
            tx_ready_d = 1'b1;
            sent_d     = 1'b1;
          end else if (bus.tx_done) begin
            sts_me_d = me_q;
            me_d     = 1'b0;
            bcr_d    = 1'b0;
            sent_d   = 1'b0;
            if (tx_after_q) begin
              state_d = ST_TX_DATA;
              cnt_d   = 5'd0;
            end else begin
              msg_done_d = 1'b1;
              msg_sa_d   = sa_q;
              msg_err_d  = me_q;
              busy_d     = 1'b0;
              state_d    = ST_IDLE;
            end
          end
        end

        ST_TX_DATA: begin
          // The buffer was addressed with cnt_d one cycle earlier, so rt_rdata is current here.
          if (!sent_q) begin
            tx_data_d  = rt_rdata;
            tx_cd_d    = 1'b1;
            tx_ready_d = 1'b1;
            sent_d     = 1'b1;
          end else if (bus.tx_done) begin
            sent_d = 1'b0;
            if (last_word) begin
              msg_done_d = 1'b1;
              msg_sa_d   = sa_q;
              msg_err_d  = sts_me_q;
              busy_d     = 1'b0;
              state_d    = ST_IDLE;
            end else begin
              cnt_d = cnt_q + 5'd1;
            end
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      sa_q       <= '0;
      wc_q       <= '0;
      tr_q       <= 1'b0;
      bcast_q    <= 1'b0;
      tx_after_q <= 1'b0;
      cnt_q      <= '0;
      timer_q    <= '0;
      sent_q     <= 1'b0;
      me_q       <= 1'b0;
      bcr_q      <= 1'b0;
      sts_me_q   <= 1'b0;
      rx_word_q  <= '0;
      perr_q     <= 1'b0;
      tx_data_q  <= '0;
      tx_cd_q    <= 1'b0;
      tx_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      msg_done_q <= 1'b0;
      msg_sa_q   <= '0;
      msg_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sa_q       <= sa_d;
      wc_q       <= wc_d;
      tr_q       <= tr_d;
      bcast_q    <= bcast_d;
      tx_after_q <= tx_after_d;
      cnt_q      <= cnt_d;
      timer_q    <= timer_d;
      sent_q     <= sent_d;
      me_q       <= me_d;
      bcr_q      <= bcr_d;
      sts_me_q   <= sts_me_d;
      rx_word_q  <= rx_word_d;
      perr_q     <= perr_d;
      tx_data_q  <= tx_data_d;
      tx_cd_q    <= tx_cd_d;
      tx_ready_q <= tx_ready_d;
      busy_q     <= busy_d;
      msg_done_q <= msg_done_d;
      msg_sa_q   <= msg_sa_d;
      msg_err_q  <= msg_err_d;
    end
  end

  assign bus.tx_data = tx_data_q;
  assign bus.tx_cd   = tx_cd_q;
  assign bus.tx_ready = tx_ready_q;
  assign busy_o      = busy_q;
  assign msg_done_o  = msg_done_q;
  assign msg_sa_o    = msg_sa_q;
  assign msg_err_o   = msg_err_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_mkio_rt_sa.sv
// Self-checking bench for mkio_rt_sa: decoder/encoder models on the bus,
// scoreboards for transmitted words and message completions.
`timescale 1ns/1ps
module tb_mkio_rt_sa;

  localparam int AW = 7;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] host_addr;
  logic          host_we;
  logic [15:0]   host_wdata, host_rdata;
  logic          busy, msg_done, msg_err;
  logic [4:0]    msg_sa;
  logic [2:0]    state;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int done_cyc = 0;
  int last_rx_cyc = 0;

  logic [16:0] exp_q[$];      // {tx_cd, tx_data}
  logic [5:0]  exp_msg_q[$];  // {msg_sa, msg_err}

  mkio_rt_sa_if bus();

  mkio_rt_sa #(
    .ADDRESS(5'd1), .NUM_SA(4), .BROADCAST_EN(1'b1), .TIMEOUT(16'd200)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .host_addr_i  (host_addr),
    .host_we_i    (host_we),
    .host_wdata_i (host_wdata),
    .host_rdata_o (host_rdata),
    .busy_o       (busy),
    .msg_done_o   (msg_done),
    .msg_sa_o     (msg_sa),
    .msg_err_o    (msg_err),
    .state_o      (state)
  );

  // ---------------- clock / cycle counter / watchdog ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  // ---------------- encoder model ----------------
  initial begin
    bus.tx_done = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.tx_ready === 1'b1) begin
        repeat ($urandom_range(1, 4)) @(negedge clk);
        bus.tx_done = 1'b1;
        done_cyc = cyc;
        @(negedge clk);
        bus.tx_done = 1'b0;
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic [16:0] e;
    logic [5:0]  m;
    logic        prev_cd;
    prev_cd = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.tx_ready === 1'b1) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL tx_word: unexpected word cd=%b data=%h, none required", bus.tx_cd, bus.tx_data);
        end else begin
          e = exp_q.pop_front();
          if ({bus.tx_cd, bus.tx_data} !== e)
            begin fails++; $display("FAIL tx_word: got cd=%b data=%h, required cd=%b data=%h", bus.tx_cd, bus.tx_data, e[16], e[15:0]); end
        end
        if (bus.tx_cd === 1'b1 && prev_cd === 1'b0) begin
          tests++;
          if (cyc - done_cyc !== 2) begin
            fails++;
            $display("FAIL first_data_latency: got %0d cycles after status tx_done, required 2", cyc - done_cyc);
          end
        end
        prev_cd = bus.tx_cd;
      end
      if (msg_done === 1'b1) begin
        tests++;
        if (exp_msg_q.size() == 0) begin
          fails++;
          $display("FAIL msg_done: unexpected pulse sa=%0d err=%b, none required", msg_sa, msg_err);
        end else begin
          m = exp_msg_q.pop_front();
          if ({msg_sa, msg_err} !== m)
            begin fails++; $display("FAIL msg_done: got sa=%0d err=%b, required sa=%0d err=%b", msg_sa, msg_err, m[5:1], m[0]); end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_word(input logic cd, input logic [15:0] d, input logic perr);
    @(negedge clk);
    bus.rx_cd = cd; bus.rx_data = d; bus.p_error = perr; bus.rx_done = 1'b1;
    last_rx_cyc = cyc;
    @(negedge clk);
    bus.rx_done = 1'b0; bus.p_error = 1'b0;
    repeat ($urandom_range(2, 6)) @(negedge clk);
  endtask

  task automatic host_write(input logic [AW-1:0] a, input logic [15:0] d);
    @(negedge clk);
    host_addr = a; host_wdata = d; host_we = 1'b1;
    @(negedge clk);
    host_we = 1'b0;
  endtask

  task automatic host_read(input logic [AW-1:0] a, output logic [15:0] d);
    @(negedge clk);
    host_addr = a; host_we = 1'b0;
    @(negedge clk);
    d = host_rdata;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while ((busy !== 1'b0 || exp_q.size() != 0 || exp_msg_q.size() != 0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (n >= 2000) begin
      fails++;
      $display("FAIL %s_complete: timed out busy=%b pending_tx=%0d pending_msg=%0d, required idle with empty queues",
               name, busy, exp_q.size(), exp_msg_q.size());
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic mode_msg(input logic [15:0] sts, input logic err);
    exp_q.push_back({1'b0, sts});
    exp_msg_q.push_back({5'd0, err});
    send_word(1'b1, 16'h0800, 1'b0);
    wait_done("mode");
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b required 0", busy); end
    tests++; if (msg_done !== 1'b0) begin fails++; $display("FAIL reset_msg_done: got %b required 0", msg_done); end
    tests++; if ({msg_sa, msg_err} !== 6'd0) begin fails++; $display("FAIL reset_msg: got sa=%0d err=%b required 0", msg_sa, msg_err); end
    tests++; if ({bus.tx_ready, bus.tx_cd, bus.tx_data} !== 18'd0)
      begin fails++; $display("FAIL reset_tx: got ready=%b cd=%b data=%h required 0", bus.tx_ready, bus.tx_cd, bus.tx_data); end
    tests++; if (host_rdata !== 16'd0) begin fails++; $display("FAIL reset_rdata: got %h required 0", host_rdata); end
    tests++; if (state !== 3'd0) begin fails++; $display("FAIL reset_state: got %0d required 0", state); end
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_receive();
    logic [15:0] d;
    logic [15:0] data [3];
    data = '{16'hA1A1, 16'hB2B2, 16'hC3C3};
    exp_q.push_back({1'b0, 16'h0800});
    exp_msg_q.push_back({5'd2, 1'b0});
    send_word(1'b1, 16'h0843, 1'b0);
    for (int k = 0; k < 3; k++) send_word(1'b0, data[k], 1'b0);
    wait_done("receive");
    for (int k = 0; k < 3; k++) begin
      host_read({2'd1, 5'(k)}, d);
      tests++;
      if (d !== data[k]) begin fails++; $display("FAIL receive_buf[%0d]: got %h required %h", k, d, data[k]); end
    end
  endtask

  task automatic test_parity();
    exp_q.push_back({1'b0, 16'h0C00});
    exp_msg_q.push_back({5'd2, 1'b1});
    send_word(1'b1, 16'h0843, 1'b0);
    send_word(1'b0, 16'h0101, 1'b0);
    send_word(1'b0, 16'h0202, 1'b1);
    send_word(1'b0, 16'h0303, 1'b0);
    wait_done("parity");
    tests++; if (msg_err !== 1'b1) begin fails++; $display("FAIL parity_msg_err: got %b required 1", msg_err); end
    exp_q.push_back({1'b0, 16'h0800});
    exp_msg_q.push_back({5'd2, 1'b0});
    send_word(1'b1, 16'h0843, 1'b0);
    for (int k = 0; k < 3; k++) send_word(1'b0, 16'h4444, 1'b0);
    wait_done("parity_next");
  endtask

  task automatic test_transmit();
    host_write({2'd0, 5'd0}, 16'h1111);
    host_write({2'd0, 5'd1}, 16'h2222);
    exp_q.push_back({1'b0, 16'h0800});
    exp_q.push_back({1'b1, 16'h1111});
    exp_q.push_back({1'b1, 16'h2222});
    exp_msg_q.push_back({5'd1, 1'b0});
    send_word(1'b1, 16'h0C22, 1'b0);
    wait_done("transmit");
  endtask

  task automatic test_broadcast();
    logic [15:0] d;
    exp_msg_q.push_back({5'd2, 1'b0});
    send_word(1'b1, 16'hF841, 1'b0);
    send_word(1'b0, 16'h5A5A, 1'b0);
    wait_done("broadcast");
    host_read({2'd1, 5'd0}, d);
    tests++; if (d !== 16'h5A5A) begin fails++; $display("FAIL broadcast_buf: got %h required 5a5a", d); end
    mode_msg(16'h0810, 1'b0);
    mode_msg(16'h0800, 1'b0);
  endtask

  task automatic test_timeout();
    int n;
    send_word(1'b1, 16'h0844, 1'b0);
    send_word(1'b0, 16'h7777, 1'b0);
    send_word(1'b0, 16'h8888, 1'b0);
    repeat (140) @(negedge clk);
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL timeout_early: got busy=%b required 1", busy); end
    n = 0;
    while (busy !== 1'b0 && n < 400) begin @(negedge clk); n++; end
    tests++;
    if (n >= 400 || cyc - last_rx_cyc < 199 || cyc - last_rx_cyc > 206) begin
      fails++;
      $display("FAIL timeout_delay: got busy=%b after %0d cycles of silence, required idle at about 200", busy, cyc - last_rx_cyc);
    end
    tests++; if (msg_err !== 1'b1) begin fails++; $display("FAIL timeout_msg_err: got %b required 1", msg_err); end
    mode_msg(16'h0C00, 1'b1);
    mode_msg(16'h0800, 1'b0);
  endtask

  task automatic test_supersede();
    logic [15:0] d;
    logic [15:0] data [3];
    data = '{16'h1D1D, 16'h2D2D, 16'h3D3D};
    exp_q.push_back({1'b0, 16'h0800});
    exp_msg_q.push_back({5'd2, 1'b0});
    send_word(1'b1, 16'h0843, 1'b0);
    send_word(1'b0, 16'hEEEE, 1'b0);
    send_word(1'b1, 16'h0843, 1'b0);
    for (int k = 0; k < 3; k++) send_word(1'b0, data[k], 1'b0);
    wait_done("supersede");
    for (int k = 0; k < 3; k++) begin
      host_read({2'd1, 5'(k)}, d);
      tests++;
      if (d !== data[k]) begin fails++; $display("FAIL supersede_buf[%0d]: got %h required %h", k, d, data[k]); end
    end
    exp_q.push_back({1'b0, 16'h0C00});
    exp_msg_q.push_back({5'd9, 1'b1});
    send_word(1'b1, 16'h0921, 1'b0);
    wait_done("bad_sa");
    mode_msg(16'h0800, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [15:0] w;
    exp_q.push_back({1'b0, 16'h0800});
    for (int k = 0; k < 32; k++) begin
      w = 16'($urandom_range(0, 65535));
      host_write({2'd3, 5'(k)}, w);
      exp_q.push_back({1'b1, w});
    end
    exp_msg_q.push_back({5'd4, 1'b0});
    send_word(1'b1, 16'h0C80, 1'b0);
    wait_done("wc32_transmit");
  endtask

  task automatic test_foreign();
    send_word(1'b1, 16'h1043, 1'b0);
    send_word(1'b0, 16'h9999, 1'b0);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL foreign_busy: got %b required 0", busy); end
    tests++; if (state !== 3'd0) begin fails++; $display("FAIL foreign_state: got %0d required 0", state); end
  endtask

  task automatic test_reset_mid();
    send_word(1'b1, 16'h0843, 1'b0);
    send_word(1'b0, 16'h6666, 1'b1);
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL mid_busy_before: got %b required 1", busy); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    tests++; if ({busy, state} !== 4'd0) begin fails++; $display("FAIL mid_reset: got busy=%b state=%0d required 0", busy, state); end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    mode_msg(16'h0800, 1'b0);
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    bus.rx_done = 1'b0; bus.rx_cd = 1'b0; bus.rx_data = '0; bus.p_error = 1'b0;
    host_addr = '0; host_we = 1'b0; host_wdata = '0;
    test_reset();
    test_receive();
    test_parity();
    test_transmit();
    test_broadcast();
    test_timeout();
    test_supersede();
    test_back_to_back();
    test_foreign();
    test_reset_mid();
    repeat (20) @(negedge clk);
    tests++;
    if (exp_q.size() != 0 || exp_msg_q.size() != 0) begin
      fails++;
      $display("FAIL final_queues: got pending_tx=%0d pending_msg=%0d required 0", exp_q.size(), exp_msg_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
